// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command monitor: ASCII codes, FSM state
// encoding, reply buffer depth and a nibble-to-hex-character helper.
// Ports: none (package).
package uart_cmd_pkg;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_K  = 8'h4B;
  localparam logic [7:0] ASCII_QM = 8'h3F;
  localparam logic [7:0] ASCII_LR = 8'h72;  // 'r'
  localparam logic [7:0] ASCII_UR = 8'h52;  // 'R'
  localparam logic [7:0] ASCII_LW = 8'h77;  // 'w'
  localparam logic [7:0] ASCII_UW = 8'h57;  // 'W'

  // Longest reply: two hex digits plus LF.
  localparam int RESP_MAX = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_EOL,
    ST_EXEC,
    ST_RDWAIT,
    ST_FLUSH,
    ST_ERR,
    ST_RESP
  } state_t;

  // Uppercase hex character for a nibble.
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/ascii_hex.sv
// Combinational ASCII/hex conversion: decodes one character into a nibble
// (with a valid flag) and encodes one byte into two uppercase hex characters.
// Ports: char_i -> valid_o/nib_o (decode); byte_i -> hi_char_o/lo_char_o (encode).
module ascii_hex
  import uart_cmd_pkg::*;
(
  input  logic [7:0] char_i,
  output logic       valid_o,
  output logic [3:0] nib_o,
  input  logic [7:0] byte_i,
  output logic [7:0] hi_char_o,
  output logic [7:0] lo_char_o
);

  always_comb begin
    valid_o = 1'b1;
    nib_o   = 4'h0;
    if (char_i >= 8'h30 && char_i <= 8'h39) begin
      nib_o = char_i[3:0];
    end else if ((char_i >= 8'h41 && char_i <= 8'h46) ||
                 (char_i >= 8'h61 && char_i <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so +9 lands on 10.
      nib_o = char_i[3:0] + 4'd9;
    end else begin
      valid_o = 1'b0;
    end
  end

  assign hi_char_o = hex_char(byte_i[7:4]);
  assign lo_char_o = hex_char(byte_i[3:0]);

endmodule

// File: rtl/uart_cmd_monitor.sv
// Line-oriented read/write command interpreter between the UART RX FIFO and
// TX FIFO, driving a byte-wide memory bus. Replies "K\n", "HH\n" or "?\n".
// Ports: CLK, reset (sync, active-low); in_empty/in_data/in_read (RX FIFO pop);
//   out_full/out_write/out_data (TX FIFO push); mem_addr/mem_wdata/mem_we/
//   mem_re/mem_rdata (memory, rdata one cycle after mem_re); busy (not IDLE).
// Option: define UART_CMD_MONITOR_ECHO_EN to echo every popped byte.
module uart_cmd_monitor
  import uart_cmd_pkg::*;
#(
  parameter int ADDR_DIGITS = 4
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     in_empty,
  input  logic [7:0]               in_data,
  output logic                     in_read,
  input  logic                     out_full,
  output logic                     out_write,
  output logic [7:0]               out_data,
  output logic [4*ADDR_DIGITS-1:0] mem_addr,
  output logic [7:0]               mem_wdata,
  output logic                     mem_we,
  output logic                     mem_re,
  input  logic [7:0]               mem_rdata,
  output logic                     busy
);

  localparam int AW = 4 * ADDR_DIGITS;
  localparam int CW = $clog2(ADDR_DIGITS + 1);

  state_t                      state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        wait_q, wait_d;
  logic                        is_wr_q, is_wr_d;
  logic [AW-1:0]               pa_q, pa_d;      // address being parsed
  logic [7:0]                  pd_q, pd_d;      // write data being parsed
  logic [AW-1:0]               addr_q, addr_d;  // committed bus address
  logic [7:0]                  wdata_q, wdata_d;
  logic [RESP_MAX-1:0][7:0]    resp_q, resp_d;
  logic [1:0]                  len_q, len_d;
  logic [1:0]                  idx_q, idx_d;

  logic       hex_vld;
  logic [3:0] hex_nib;
  logic [7:0] rd_hi, rd_lo;
  logic       rx_st, pop, take;

  ascii_hex u_hex (
    .char_i   (in_data),
    .valid_o  (hex_vld),
    .nib_o    (hex_nib),
    .byte_i   (mem_rdata),
    .hi_char_o(rd_hi),
    .lo_char_o(rd_lo)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wait_d    = 1'b0;
    is_wr_d   = is_wr_q;
    pa_d      = pa_q;
    pd_d      = pd_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    resp_d    = resp_q;
    len_d     = len_q;
    idx_d     = idx_q;
    in_read   = 1'b0;
    out_write = 1'b0;
    out_data  = 8'h00;
    mem_we    = 1'b0;
    mem_re    = 1'b0;

    rx_st = (state_q == ST_IDLE) || (state_q == ST_ADDR) || (state_q == ST_DATA) ||
            (state_q == ST_EOL)  || (state_q == ST_FLUSH);
    // wait_q blocks the cycle right after a pop so the FIFO head can settle.
`ifdef UART_CMD_MONITOR_ECHO_EN
    pop = rx_st && !wait_q && !in_empty && !out_full && reset;
`else
    pop = rx_st && !wait_q && !in_empty && reset;
`endif
    take = pop && (in_data != ASCII_CR);

    if (pop) begin
      in_read = 1'b1;
      wait_d  = 1'b1;
`ifdef UART_CMD_MONITOR_ECHO_EN
      out_write = 1'b1;
      out_data  = in_data;
`endif
    end

    unique case (state_q)
      ST_IDLE: if (take) begin
        if (in_data == ASCII_LR || in_data == ASCII_UR) begin
          state_d = ST_ADDR; is_wr_d = 1'b0; cnt_d = '0;
        end else if (in_data == ASCII_LW || in_data == ASCII_UW) begin
          state_d = ST_ADDR; is_wr_d = 1'b1; cnt_d = '0;
        end else if (in_data != ASCII_LF) begin
          state_d = ST_FLUSH;
        end
      end
      ST_ADDR: if (take) begin
        if (in_data == ASCII_LF)  state_d = ST_ERR;
        else if (!hex_vld)        state_d = ST_FLUSH;
        else begin
          pa_d = (pa_q << 4) | AW'(hex_nib);
          if (cnt_q == CW'(ADDR_DIGITS - 1)) begin
            cnt_d   = '0;
            state_d = is_wr_q ? ST_DATA : ST_EOL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DATA: if (take) begin
        if (in_data == ASCII_LF)  state_d = ST_ERR;
        else if (!hex_vld)        state_d = ST_FLUSH;
        else begin
          pd_d = {pd_q[3:0], hex_nib};
          if (cnt_q == CW'(1)) begin
            cnt_d   = '0;
            state_d = ST_EOL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_EOL: if (take) begin
        if (in_data == ASCII_LF) begin
          // Commit the bus values only now so they hold outside strobes.
          state_d = ST_EXEC;
          addr_d  = pa_q;
          wdata_d = pd_q;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: if (take && in_data == ASCII_LF) state_d = ST_ERR;
      ST_EXEC: begin
        if (is_wr_q) begin
          mem_we    = reset;
          resp_d[0] = ASCII_K;
          resp_d[1] = ASCII_LF;
          len_d     = 2'd2;
          idx_d     = 2'd0;
          state_d   = ST_RESP;
        end else begin
          mem_re  = reset;
          state_d = ST_RDWAIT;
        end
      end
      ST_RDWAIT: begin
        resp_d[0] = rd_hi;
        resp_d[1] = rd_lo;
        resp_d[2] = ASCII_LF;
        len_d     = 2'd3;
        idx_d     = 2'd0;
        state_d   = ST_RESP;
      end
      ST_ERR: begin
        resp_d[0] = ASCII_QM;
        resp_d[1] = ASCII_LF;
        len_d     = 2'd2;
        idx_d     = 2'd0;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        out_data = resp_q[idx_q];
        if (!out_full && reset) begin
          out_write = 1'b1;
          if (idx_q == len_q - 2'd1) begin
            idx_d   = 2'd0;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wait_q  <= 1'b0;
      is_wr_q <= 1'b0;
      pa_q    <= '0;
      pd_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      resp_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      is_wr_q <= is_wr_d;
      pa_q    <= pa_d;
      pd_q    <= pd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      resp_q  <= resp_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
